execute_muldiv: RTL and testbench

EXECUTE_MULDIV -- requirements
Module: execute_muldiv

---
 rtl/execute_muldiv.sv | 147 ++++++++++++++
 tb/tb_execute_muldiv.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide unit for the Execute stage: 32-cycle shift-add / restoring divide.
// Define MULDIV_DIV_EN to build the divider; otherwise ops 4-7 complete at once with a zero result.
module execute_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             StartE,
    input  logic [2:0]       MulDivOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic [4:0]       RdE,
    input  logic             FlushE,
    output logic             BusyE,
    output logic             DoneE,
    output logic [WIDTH-1:0] ResultE,
    output logic [4:0]       RdDoneE
);
    localparam logic [2:0] OP_MUL = 3'd0;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t             r_state;
    logic [4:0]         r_cnt;
    logic [2:0]         r_op;
    logic [4:0]         r_rd;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_neg;
    logic [WIDTH-1:0]   r_result;

    // Operand signedness: MUL/MULH both signed, MULHSU only rs1, DIV/REM both.
    logic             w_is_div, w_mul_sa, w_mul_sb, w_div_s, w_sa, w_sb;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    assign w_is_div = MulDivOpE[2];
    assign w_mul_sa = ~MulDivOpE[2] & (MulDivOpE[1:0] != 2'd3);
    assign w_mul_sb = ~MulDivOpE[2] & (MulDivOpE[1:0] <= 2'd1);
    assign w_div_s  = MulDivOpE[2] & ~MulDivOpE[0];
    assign w_sa     = (w_mul_sa | w_div_s) & SrcAE[WIDTH-1];
    assign w_sb     = (w_mul_sb | w_div_s) & SrcBE[WIDTH-1];
    assign w_mag_a  = w_sa ? -SrcAE : SrcAE;
    assign w_mag_b  = w_sb ? -SrcBE : SrcBE;

    logic             w_special;
    logic [WIDTH-1:0] w_special_res;

    // Multiply step: accumulate into the high half while the multiplier shifts out of the low half.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next, w_acc_next, w_prod;
    logic [WIDTH-1:0]   w_final;
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_prod     = r_neg ? -w_acc_next : w_acc_next;

`ifdef MULDIV_DIV_EN
    logic               r_neg_rem;
    logic               w_div_zero, w_div_ovf;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_quot, w_rem;

    assign w_div_zero    = w_is_div & (SrcBE == '0);
    assign w_div_ovf     = w_div_s & (SrcAE == 32'h8000_0000) & (SrcBE == 32'hFFFF_FFFF);
    assign w_special     = w_div_zero | w_div_ovf;
    assign w_special_res = w_div_zero ? (MulDivOpE[1] ? SrcAE : '1)
                                      : (MulDivOpE[1] ? '0 : 32'h8000_0000);

    // Restoring step: remainder/quotient pair shifts left, subtract succeeds when no borrow.
    assign w_div_trial = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
    assign w_div_next  = w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                            : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    assign w_acc_next  = r_op[2] ? w_div_next : w_mul_next;
    assign w_quot      = r_neg ? -w_acc_next[WIDTH-1:0] : w_acc_next[WIDTH-1:0];
    assign w_rem       = r_neg_rem ? -w_acc_next[2*WIDTH-1:WIDTH] : w_acc_next[2*WIDTH-1:WIDTH];

    always_comb begin
        w_final = '0;
        if (r_op[2])             w_final = r_op[1] ? w_rem : w_quot;
        else if (r_op == OP_MUL) w_final = w_prod[WIDTH-1:0];
        else                     w_final = w_prod[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_neg_rem <= 1'b0;
        else if (r_state == S_IDLE && StartE && !FlushE)
            r_neg_rem <= w_sa;
    end
`else
    assign w_special     = w_is_div;
    assign w_special_res = '0;
    assign w_acc_next    = w_mul_next;
    assign w_final       = (r_op == OP_MUL) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (StartE && !FlushE) begin
                        r_op  <= MulDivOpE;
                        r_rd  <= RdE;
                        r_cnt <= '0;
                        r_neg <= w_sa ^ w_sb;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_state  <= S_DONE;
                        end else begin
                            r_acc   <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                            r_opnd  <= w_is_div ? w_mag_b : w_mag_a;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (FlushE) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_result <= w_final;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign BusyE   = RST_N & ((r_state == S_CALC) | ((r_state == S_IDLE) & StartE & ~FlushE));
    assign DoneE   = (r_state == S_DONE);
    assign ResultE = r_result;
    assign RdDoneE = r_rd;
endmodule

// File: tb/tb_execute_muldiv.sv
// Scoreboard bench for execute_muldiv: arithmetic reference model, directed corners plus random ops.
module tb_execute_muldiv;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        StartE = 1'b0;
    logic        FlushE = 1'b0;
    logic [2:0]  MulDivOpE = '0;
    logic [31:0] SrcAE = '0, SrcBE = '0;
    logic [4:0]  RdE = '0;
    logic        BusyE, DoneE;
    logic [31:0] ResultE;
    logic [4:0]  RdDoneE;

    execute_muldiv #(.WIDTH(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .StartE(StartE), .MulDivOpE(MulDivOpE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .RdE(RdE), .FlushE(FlushE),
        .BusyE(BusyE), .DoneE(DoneE), .ResultE(ResultE), .RdDoneE(RdDoneE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          done_cyc;
    } exp_t;
    exp_t sb_q[$];

    // Reference model straight from the RV32M definitions using 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        r  = '0;
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
`ifdef MULDIV_DIV_EN
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else begin p = ua / ub; r = p[31:0]; end
            end
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            3'd7: begin
                if (b == 0) r = a;
                else begin p = ua % ub; r = p[31:0]; end
            end
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_DIV_EN
        return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`else
        return op[2];
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every DoneE strobe must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (DoneE) begin
            exp_t e;
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got result=%h rd=%0d, required no DoneE", ResultE, RdDoneE);
            end else begin
                e = sb_q.pop_front();
                if (ResultE !== e.res || RdDoneE !== e.rd || cyc != e.done_cyc || BusyE !== 1'b0) begin
                    fails++;
                    $display("FAIL result: got res=%h rd=%0d cyc=%0d busy=%b, required res=%h rd=%0d cyc=%0d busy=0",
                             ResultE, RdDoneE, cyc, BusyE, e.res, e.rd, e.done_cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic quiet(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            check("quiet_no_done", {63'b0, DoneE}, 64'd0);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit hold);
        exp_t e;
        int   n_busy;
        bit   seen;
        @(negedge CLK);
        StartE = 1'b1; MulDivOpE = op; SrcAE = a; SrcBE = b; RdE = rd;
        e.res      = model(op, a, b);
        e.rd       = rd;
        e.done_cyc = cyc + 1 + (is_fast(op, a, b) ? 0 : 32);
        sb_q.push_back(e);
        #1;
        check("busy_on_start", {63'b0, BusyE}, 64'd1);
        n_busy = 1;
        seen   = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge CLK);
            if (hold && !DoneE) begin
                StartE = 1'b1; MulDivOpE = 3'($urandom); SrcAE = $urandom; SrcBE = $urandom;
            end else begin
                StartE = 1'b0;
            end
            if (DoneE) seen = 1'b1;
            else n_busy += int'(BusyE);
        end
        StartE = 1'b0;
        if (!seen) begin
            tests++; fails++;
            $display("FAIL done_timeout: got no DoneE in 100 cycles, required one");
            sb_q.delete();
        end
        check("busy_cycles", 64'(n_busy), is_fast(op, a, b) ? 64'd1 : 64'd33);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        check("reset_outputs", {30'b0, BusyE, DoneE, ResultE}, 64'd0);
        check("reset_rd", {59'b0, RdDoneE}, 64'd0);
        RST_N = 1'b1;

        issue(3'd0, 32'd7, 32'hFFFF_FFFA, 5'd11, 1'b0);

        // Reset mid-CALC clears everything immediately, then the very next start is accepted
        @(negedge CLK);
        StartE = 1'b1; MulDivOpE = 3'd0; SrcAE = 32'd3; SrcBE = 32'd5; RdE = 5'd9;
        @(negedge CLK);
        StartE = 1'b0;
        repeat (20) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("reset_midcalc", {30'b0, BusyE, DoneE, ResultE}, 64'd0);
        check("reset_midcalc_rd", {59'b0, RdDoneE}, 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 1'b0);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b0);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
        issue(3'd5, 32'd100, 32'd0, 5'd7, 1'b0);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b0);
        issue(3'd4, 32'd9, 32'd3, 5'd10, 1'b0);
        issue(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd12, 1'b0);

        // Flush at iteration 10 discards the op; a new MUL right after completes
        @(negedge CLK);
        StartE = 1'b1; MulDivOpE = 3'd0; SrcAE = 32'd123; SrcBE = 32'd456; RdE = 5'd13;
        @(negedge CLK);
        StartE = 1'b0;
        repeat (10) @(negedge CLK);
        FlushE = 1'b1;
        @(negedge CLK);
        FlushE = 1'b0;
        check("flush_to_idle", {62'b0, BusyE, DoneE}, 64'd0);
        quiet(36);
        issue(3'd0, 32'd123, 32'd456, 5'd14, 1'b0);

        // Flush together with start in IDLE starts nothing
        @(negedge CLK);
        StartE = 1'b1; FlushE = 1'b1; MulDivOpE = 3'd0; SrcAE = 32'd2; SrcBE = 32'd2;
        #1;
        check("flush_start_busy", {63'b0, BusyE}, 64'd0);
        @(negedge CLK);
        StartE = 1'b0; FlushE = 1'b0;
        check("flush_start_idle", {63'b0, BusyE}, 64'd0);
        quiet(36);

        // StartE held through CALC and DONE yields exactly one DoneE
        issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd15, 1'b1);
        quiet(36);

        for (int i = 0; i < 50; i++)
            issue(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom), 1'($urandom_range(0, 1)));
        quiet(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
